pipe_alu_checker: RTL and testbench

- Synthesizable in-pipeline self-checker for the RISC-V CPU.
- Captures each instruction leaving ID with its operand values and computes a golden ALU result.
- Carries that result through a parametrised shadow pipeline that honours stall and flush, and compares it against the EX-stage ALU result.
- Exposes per-check status, pass/error counters and a cycle-budget timeout, so benches and FPGA debug share one checker.

---
 rtl/pipe_check_pkg.sv | 100 ++++++++++
 rtl/pipe_alu_checker_alu_ref_model.sv | 26 ++
 rtl/pipe_alu_checker.sv | 112 +++++++++++
 tb/tb_pipe_alu_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_check_pkg.sv
// Shared types and golden ALU function for the
// in-pipeline ALU self-checker.
package pipe_check_pkg;

  localparam int XMAX = 64;

  typedef enum logic [6:0] {
    ALU_OP   = 7'b0110011,
    ALU_OP_I = 7'b0010011,
    LOAD     = 7'b0000011,
    STORE    = 7'b0100011,
    BRANCH   = 7'b1100011
  } opcode_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic            checkable;
    logic [XMAX-1:0] expected;
  } gold_t;

  typedef struct packed {
    logic            valid;
    logic            checkable;
    logic [31:0]     instr;
    logic [XMAX-1:0] expected;
  } entry_t;

  // RV32 operands are sign-extended to 64 bits so one datapath
  // serves both widths; SRL uses the zero-extended copy instead.
  function automatic gold_t alu_golden(
    input logic [31:0]     instr,
    input logic [XMAX-1:0] rs1,
    input logic [XMAX-1:0] rs2,
    input logic            w64
  );
    gold_t       g;
    logic [63:0] ra_s;
    logic [63:0] ra_z;
    logic [63:0] rb;
    logic [63:0] r;
    logic [5:0]  sh;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        alt;
    logic        is_r;
    logic        ok;
    op   = instr[6:0];
    f3   = instr[14:12];
    f7   = instr[31:25];
    alt  = instr[30];
    is_r = (op == ALU_OP);
    ra_s = w64 ? rs1 : {{32{rs1[31]}}, rs1[31:0]};
    ra_z = w64 ? rs1 : {32'b0, rs1[31:0]};
    if (is_r)
      rb = w64 ? rs2 : {{32{rs2[31]}}, rs2[31:0]};
    else
      rb = {{52{instr[31]}}, instr[31:20]};
    sh = w64 ? rb[5:0] : {1'b0, rb[4:0]};
    ok = 1'b0;
    unique case (1'b1)
      (op == ALU_OP):
        ok = (f7 == F7_BASE) ||
             ((f7 == F7_ALT) &&
              ((f3 == F3_ADD) || (f3 == F3_SR)));
      (op == ALU_OP_I):
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    r = '0;
    case (f3)
      F3_ADD:  r = (is_r && alt) ? ra_s - rb : ra_s + rb;
      F3_SLL:  r = ra_s << sh;
      F3_SLT:  r = {63'b0, $signed(ra_s) < $signed(rb)};
      F3_SLTU: r = {63'b0, ra_s < rb};
      F3_XOR:  r = ra_s ^ rb;
      F3_SR:   r = alt ? 64'($signed(ra_s) >>> sh)
                       : ra_z >> sh;
      F3_OR:   r = ra_s | rb;
      F3_AND:  r = ra_s & rb;
      default: r = '0;
    endcase
    g.checkable = ok;
    g.expected  = w64 ? r : {32'b0, r[31:0]};
    return g;
  endfunction

endpackage

// File: rtl/pipe_alu_checker_alu_ref_model.sv
// Combinational golden ALU used at the ID capture point.
// Expected value is zero-extended to the package width.
module alu_ref_model
  import pipe_check_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_checkable,
  output logic [XMAX-1:0] o_expected
);

  gold_t w_gold;

  // Evaluate the golden model on the zero-extended operands
  always_comb begin
    w_gold = alu_golden(i_instr, XMAX'(i_rs1), XMAX'(i_rs2),
                        (XLEN == 64));
  end

  assign o_checkable = w_gold.checkable;
  assign o_expected  = w_gold.expected;

endmodule

// File: rtl/pipe_alu_checker.sv
// Shadow pipeline that carries golden ALU results from ID
// and compares them against the EX-stage result.
module pipe_alu_checker
  import pipe_check_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 1,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_instr_i,
  input  logic [XLEN-1:0]  rs1_val_i,
  input  logic [XLEN-1:0]  rs2_val_i,
  input  logic [XLEN-1:0]  ex_result_i,
  output logic             chk_valid_o,
  output logic             chk_pass_o,
  output logic [31:0]      chk_instr_o,
  output logic [XLEN-1:0]  exp_result_o,
  output logic [XLEN-1:0]  act_result_o,
  output logic [CNT_W-1:0] checked_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             timeout_o
);

  entry_t          r_entry [DEPTH];
  entry_t          w_cap;
  entry_t          w_tail;
  logic            w_ref_chk;
  logic [XMAX-1:0] w_ref_exp;
  logic            w_adv;
  logic            w_do_chk;
  logic            w_match;
  logic [31:0]     r_cyc;

  alu_ref_model #(.XLEN(XLEN)) u_ref (
    .i_instr     (id_instr_i),
    .i_rs1       (rs1_val_i),
    .i_rs2       (rs2_val_i),
    .o_checkable (w_ref_chk),
    .o_expected  (w_ref_exp)
  );

  // Build the ID capture entry and the tail compare decision
  always_comb begin
    w_cap.valid     = id_valid_i;
    w_cap.checkable = w_ref_chk;
    w_cap.instr     = id_instr_i;
    w_cap.expected  = w_ref_exp;
    w_tail          = r_entry[DEPTH-1];
    w_adv           = !stall_i && !flush_i;
    w_do_chk        = w_adv && w_tail.valid &&
                      w_tail.checkable;
    w_match         = (ex_result_i ==
                       w_tail.expected[XLEN-1:0]);
  end

  // Shadow shift register: flush clears, stall holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (!stall_i) begin
      r_entry[0] <= w_cap;
      for (int i = 1; i < DEPTH; i++)
        r_entry[i] <= r_entry[i-1];
    end
  end

  // Register check results and saturating counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_valid_o   <= 1'b0;
      chk_pass_o    <= 1'b0;
      chk_instr_o   <= '0;
      exp_result_o  <= '0;
      act_result_o  <= '0;
      checked_cnt_o <= '0;
      err_cnt_o     <= '0;
    end else begin
      chk_valid_o <= w_do_chk;
      if (w_do_chk) begin
        chk_pass_o   <= w_match;
        chk_instr_o  <= w_tail.instr;
        exp_result_o <= w_tail.expected[XLEN-1:0];
        act_result_o <= ex_result_i;
        if (checked_cnt_o != '1)
          checked_cnt_o <= checked_cnt_o + 1'b1;
        if (!w_match && (err_cnt_o != '1))
          err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

  // Cycle budget: counter stops once the timeout latches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cyc     <= '0;
      timeout_o <= 1'b0;
    end else if ((MAX_CYCLES != 0) && !timeout_o) begin
      r_cyc <= r_cyc + 1'b1;
      if (r_cyc == 32'(MAX_CYCLES - 1))
        timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_alu_checker.sv
// Directed bench: DEPTH=1 and DEPTH=2 checkers on shared
// stimulus, with hand-computed expected results.
module tb_pipe_alu_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_v = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] exr = '0;

  logic        v1, p1, v2, p2, to1, to2;
  logic [31:0] i1, e1, a1, i2, e2, a2;
  logic [15:0] c1, r1, c2, r2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_alu_checker #(.XLEN(32), .DEPTH(1), .CNT_W(16),
                     .MAX_CYCLES(30)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .flush_i(flush), .id_valid_i(id_v), .id_instr_i(instr),
    .rs1_val_i(rs1), .rs2_val_i(rs2), .ex_result_i(exr),
    .chk_valid_o(v1), .chk_pass_o(p1), .chk_instr_o(i1),
    .exp_result_o(e1), .act_result_o(a1),
    .checked_cnt_o(c1), .err_cnt_o(r1), .timeout_o(to1)
  );

  pipe_alu_checker #(.XLEN(32), .DEPTH(2), .CNT_W(16),
                     .MAX_CYCLES(30)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .flush_i(flush), .id_valid_i(id_v), .id_instr_i(instr),
    .rs1_val_i(rs1), .rs2_val_i(rs2), .ex_result_i(exr),
    .chk_valid_o(v2), .chk_pass_o(p2), .chk_instr_o(i2),
    .exp_result_o(e2), .act_result_o(a2),
    .checked_cnt_o(c2), .err_cnt_o(r2), .timeout_o(to2)
  );

  function automatic logic [31:0] rtype(
    input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(
    input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros1(input string tag);
    chk({tag, "_valid"}, 64'(v1), 64'd0);
    chk({tag, "_pass"}, 64'(p1), 64'd0);
    chk({tag, "_instr"}, 64'(i1), 64'd0);
    chk({tag, "_exp"}, 64'(e1), 64'd0);
    chk({tag, "_act"}, 64'(a1), 64'd0);
    chk({tag, "_cnt"}, 64'(c1), 64'd0);
    chk({tag, "_err"}, 64'(r1), 64'd0);
    chk({tag, "_to"}, 64'(to1), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_v  = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;
  logic [31:0] add_i, sub_i, sltu_i, srai_i, bad_i;

  initial begin
    add_i  = rtype(7'b0000000, 3'b000);
    sub_i  = rtype(7'b0100000, 3'b000);
    sltu_i = rtype(7'b0000000, 3'b011);
    bad_i  = rtype(7'b0100000, 3'b100);
    srai_i = itype(12'h404, 3'b101);

    #2;
    zeros1("rst");
    step();
    rst_n = 1'b1;

    // ADDI then ADD on DEPTH=1
    id_v = 1'b1; instr = ADDI; rs1 = 0; rs2 = 0;
    step();
    instr = add_i; rs1 = 5; rs2 = 7; exr = 5;
    step();
    chk("addi_v", 64'(v1), 64'd1);
    chk("addi_p", 64'(p1), 64'd1);
    chk("addi_e", 64'(e1), 64'd5);
    chk("addi_i", 64'(i1), 64'h0050_0093);
    id_v = 1'b0; exr = 12;
    step();
    chk("add_v", 64'(v1), 64'd1);
    chk("add_p", 64'(p1), 64'd1);
    chk("add_e", 64'(e1), 64'd12);
    chk("add_c", 64'(c1), 64'd2);
    chk("add_r", 64'(r1), 64'd0);
    step();
    chk("pulse", 64'(v1), 64'd0);
    chk("hold_e", 64'(e1), 64'd12);

    // SUB mismatch
    id_v = 1'b1; instr = sub_i; rs1 = 3; rs2 = 5;
    step();
    id_v = 1'b0; exr = 32'hFFFF_FFFD;
    step();
    chk("sub_v", 64'(v1), 64'd1);
    chk("sub_p", 64'(p1), 64'd0);
    chk("sub_e", 64'(e1), 64'hFFFF_FFFE);
    chk("sub_a", 64'(a1), 64'hFFFF_FFFD);
    chk("sub_r", 64'(r1), 64'd1);
    chk("sub_c", 64'(c1), 64'd3);

    // DEPTH=2 with a 3-cycle stall
    do_reset();
    id_v = 1'b1; instr = add_i; rs1 = 1; rs2 = 1; exr = 2;
    step();
    id_v = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_v", 64'(v2), 64'd0);
    end
    stall = 1'b0;
    step();
    chk("stall_v4", 64'(v2), 64'd0);
    step();
    chk("stall_v5", 64'(v2), 64'd1);
    chk("stall_p", 64'(p2), 64'd1);
    chk("stall_e", 64'(e2), 64'd2);

    // DEPTH=2 flush+stall on the tail edge
    id_v = 1'b1;
    step();
    id_v = 1'b0;
    step();
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush_v", 64'(v2), 64'd0);
    chk("flush_c", 64'(c2), 64'd1);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("flush_v2", 64'(v2), 64'd0);
    step();
    chk("flush_c2", 64'(c2), 64'd1);
    chk("flush_r2", 64'(r2), 64'd0);

    // SRAI, SLTU, LOAD, illegal funct7 on DEPTH=1
    do_reset();
    id_v = 1'b1; instr = srai_i; rs1 = 32'h8000_0000;
    step();
    instr = sltu_i; rs1 = 1; rs2 = 32'hFFFF_FFFF;
    exr = 32'hF800_0000;
    step();
    chk("srai_v", 64'(v1), 64'd1);
    chk("srai_e", 64'(e1), 64'hF800_0000);
    chk("srai_p", 64'(p1), 64'd1);
    instr = 32'h0000_A183; exr = 1;
    step();
    chk("sltu_e", 64'(e1), 64'd1);
    chk("sltu_p", 64'(p1), 64'd1);
    instr = bad_i;
    step();
    chk("load_v", 64'(v1), 64'd0);
    id_v = 1'b0;
    step();
    chk("bad_v", 64'(v1), 64'd0);
    chk("bad_c", 64'(c1), 64'd2);

    // Timeout after 30 edges, then reset mid-check
    do_reset();
    for (int k = 0; k < 29; k++) step();
    chk("to_29", 64'(to1), 64'd0);
    step();
    chk("to_30", 64'(to1), 64'd1);
    for (int k = 0; k < 3; k++) step();
    chk("to_hold", 64'(to1), 64'd1);
    id_v = 1'b1; instr = sub_i; rs1 = 3; rs2 = 5;
    step();
    id_v = 1'b0; exr = 32'hFFFF_FFFE;
    step();
    chk("late_v", 64'(v1), 64'd1);
    chk("late_p", 64'(p1), 64'd1);
    rst_n = 1'b0;
    #1;
    zeros1("mid");
    chk("mid_to2", 64'(to2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
